// File: rtl/dekatron_counter_responder.sv
// Multi-digit BCD counter that steps one digit at a time with a hold delay per step,
// imitating a chain of dekatron tubes where carry/borrow ripples serially upward.
module dekatron_counter_responder #(
  parameter int DEKATRON_NUM   = 6,
  parameter int DEKATRON_WIDTH = 4,
  parameter int COUNT_DELAY    = 3
) (
  input  logic                                     Clk,
  input  logic                                     Rst_n,
  input  logic                                     Request,
  input  logic                                     Dec,
  input  logic                                     Set,
  input  logic [DEKATRON_NUM*DEKATRON_WIDTH-1:0]   In,
  output logic                                     Ready,
  output logic [DEKATRON_NUM*DEKATRON_WIDTH-1:0]   Out,
  output logic                                     Zero
);

  localparam int W  = DEKATRON_WIDTH;
  localparam int IW = (DEKATRON_NUM > 1) ? $clog2(DEKATRON_NUM) : 1;
  localparam int CW = (COUNT_DELAY > 1) ? $clog2(COUNT_DELAY) : 1;

  localparam logic [W-1:0]  NINE     = W'(9);
  localparam logic [W-1:0]  ONE      = W'(1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DEKATRON_NUM - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(COUNT_DELAY - 1);

  typedef enum logic [1:0] {IDLE, STEP, DELAY} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  digit [DEKATRON_NUM];
  logic [IW-1:0] idx;
  logic [CW-1:0] dcnt;
  logic          carry;
  logic          dec_r;
  logic [W-1:0]  cur_digit;
  logic [W:0]    step_res;

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] d);
    return (d > NINE) ? '0 : d;
  endfunction

  // Result packs {carry/borrow, new digit}.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] d);
    return (d == NINE) ? {1'b1, {W{1'b0}}} : {1'b0, d + ONE};
  endfunction

  function automatic logic [W:0] bcd_dec(input logic [W-1:0] d);
    return (d == '0) ? {1'b1, NINE} : {1'b0, d - ONE};
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Request) state_nxt = Set ? DELAY : STEP;
      STEP:    state_nxt = DELAY;
      DELAY:   if (dcnt == '0) state_nxt = (carry && (idx < IDX_MAX)) ? STEP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DEKATRON_NUM; i++)
      if (idx == IW'(i)) cur_digit = digit[i];
    step_res = dec_r ? bcd_dec(cur_digit) : bcd_inc(cur_digit);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEKATRON_NUM; i++) digit[i] <= '0;
      idx   <= '0;
      dcnt  <= '0;
      carry <= 1'b0;
      dec_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Request) begin
          if (Set) begin
            for (int i = 0; i < DEKATRON_NUM; i++) digit[i] <= bcd_clamp(In[i*W +: W]);
            dcnt  <= CNT_INIT;
            carry <= 1'b0;
          end else begin
            dec_r <= Dec;
            idx   <= '0;
          end
        end
        STEP: begin
          for (int i = 0; i < DEKATRON_NUM; i++)
            if (idx == IW'(i)) digit[i] <= step_res[W-1:0];
          carry <= step_res[W];
          dcnt  <= CNT_INIT;
        end
        DELAY: begin
          if (dcnt == '0) begin
            if (carry && (idx < IDX_MAX)) idx <= idx + IW'(1);
            else                          carry <= 1'b0;
          end else begin
            dcnt <= dcnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < DEKATRON_NUM; g++) begin : g_out
    assign Out[g*W +: W] = digit[g];
  end

  assign Ready = (state == IDLE);
  assign Zero  = (Out == '0);

endmodule
